// File: rtl/mul_rr_scheduler.sv
// Round-robin scheduler sharing one Booth radix-8 / carry-save 32x32 signed multiplier among NREQ requesters.
// Define MUL_RR_SCHED_PIPE_EN to register the carry-save outputs before the final adder (3-cycle latency).
module mul_rr_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*32-1:0]   req_a,
  input  logic [NREQ*32-1:0]   req_b,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [IDW-1:0]       rsp_id,
  output logic [63:0]          rsp_p,
  output logic                 busy
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // req_ready is combinational from pointer, occupancy and req_valid, and is low during reset.

  logic            s1_v_q;
  logic [IDW-1:0]  s1_id_q;
  logic [31:0]     s1_a_q;
  logic [31:0]     s1_b_q;
  logic [IDW-1:0]  ptr_q, ptr_d;
  logic            s2_v_q;
  logic [IDW-1:0]  s2_id_q;
  logic [63:0]     s2_p_q;

  logic            s1_free, s2_free;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;

  logic [63:0]     out1, out2;
  logic            add_v;
  logic [IDW-1:0]  add_id;
  logic [63:0]     add_x, add_y;
  logic [63:0]     result_output;

  assign s2_free = !s2_v_q || rsp_ready;

  always_comb begin
    int   idx;
    logic found;
    grant    = '0;
    grant_id = '0;
    found    = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      idx = int'(ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (!found && req_valid[idx]) begin
        found      = 1'b1;
        grant_id   = IDW'(idx);
        grant[idx] = s1_free && !rst;
      end
    end
  end

  assign grant_any = |grant;
  assign req_ready = grant;

  always_comb begin
    ptr_d = ptr_q;
    if (grant_any) ptr_d = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + 1'b1;
  end

  // Radix-8 Booth digits over sign-extended B, each partial product folded into a carry-save pair.
  always_comb begin
    logic [63:0] a1, a3, mag, pp, s, c, cy;
    logic [34:0] bx;
    logic [3:0]  t;
    logic        neg;
    a1 = {{32{s1_a_q[31]}}, s1_a_q};
    a3 = a1 + (a1 << 1);
    bx = {{2{s1_b_q[31]}}, s1_b_q, 1'b0};
    s  = '0;
    c  = '0;
    for (int j = 0; j < 11; j++) begin
      t   = bx[3*j +: 4];
      neg = t[3];
      case (t)
        4'd1, 4'd2, 4'd13, 4'd14: mag = a1;
        4'd3, 4'd4, 4'd11, 4'd12: mag = a1 << 1;
        4'd5, 4'd6, 4'd9, 4'd10:  mag = a3;
        4'd7, 4'd8:               mag = a1 << 2;
        default:                  mag = '0;
      endcase
      pp = neg ? (~mag + 64'd1) : mag;
      pp = pp << (3 * j);
      cy = (s & c) | (s & pp) | (c & pp);
      s  = s ^ c ^ pp;
      c  = cy << 1;
    end
    out1 = s;
    out2 = c;
  end

`ifdef MUL_RR_SCHED_PIPE_EN
  logic            sw_v_q;
  logic [IDW-1:0]  sw_id_q;
  logic [63:0]     sw_o1_q, sw_o2_q;
  logic            sw_free;

  assign sw_free = !sw_v_q || s2_free;
  assign s1_free = !s1_v_q || sw_free;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sw_v_q  <= 1'b0;
      sw_id_q <= '0;
      sw_o1_q <= '0;
      sw_o2_q <= '0;
    end else if (sw_free) begin
      sw_v_q  <= s1_v_q;
      sw_id_q <= s1_id_q;
      sw_o1_q <= out1;
      sw_o2_q <= out2;
    end
  end

  assign add_v  = sw_v_q;
  assign add_id = sw_id_q;
  assign add_x  = sw_o1_q;
  assign add_y  = sw_o2_q;
  assign busy   = s1_v_q | sw_v_q | s2_v_q;
`else
  assign s1_free = !s1_v_q || s2_free;
  assign add_v   = s1_v_q;
  assign add_id  = s1_id_q;
  assign add_x   = out1;
  assign add_y   = out2;
  assign busy    = s1_v_q | s2_v_q;
`endif

  assign result_output = add_x + add_y;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_v_q  <= 1'b0;
      s1_id_q <= '0;
      s1_a_q  <= '0;
      s1_b_q  <= '0;
      ptr_q   <= '0;
    end else begin
      ptr_q <= ptr_d;
      if (grant_any) begin
        s1_v_q  <= 1'b1;
        s1_id_q <= grant_id;
        s1_a_q  <= req_a[32*grant_id +: 32];
        s1_b_q  <= req_b[32*grant_id +: 32];
      end else if (s1_free) begin
        s1_v_q <= 1'b0;
      end
    end
  end

  // S2 holds its contents stable while the consumer back-pressures.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_v_q  <= 1'b0;
      s2_id_q <= '0;
      s2_p_q  <= '0;
    end else if (s2_free) begin
      s2_v_q <= add_v;
      if (add_v) begin
        s2_id_q <= add_id;
        s2_p_q  <= result_output;
      end
    end
  end

  assign rsp_valid = s2_v_q;
  assign rsp_id    = s2_id_q;
  assign rsp_p     = s2_p_q;

endmodule

// File: doc/mul_rr_scheduler.md
# mul_rr_scheduler

Round-robin scheduler that shares one Booth radix-8 Wallace-tree 32x32 multiplier (`result_output`) between NREQ requesters. Each requester presents signed operands over a valid/ready handshake. The scheduler grants one request per cycle, registers the operands, drives the shared multiplier, and returns the 64-bit product tagged with the requester ID over a single valid/ready response channel. It sits between the integer issue ports and the shared multiply resource.

## Interface
- NREQ, 4, number of requesters; legal range 2..8.
- IDW, 3, width of `rsp_id`; must satisfy 2^IDW >= NREQ.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_ready  out  NREQ  per-requester grant; one-hot or zero.
- req_a  in  NREQ*32  operand A, requester i at [32i+31:32i]; two's complement.
- req_b  in  NREQ*32  operand B, same packing.
- rsp_valid  out  1  product valid.
- rsp_ready  in  1  consumer accepts product.
- rsp_id  out  IDW  index of the requester that owns the product.
- rsp_p  out  64  signed product A*B.
- busy  out  1  high while any pipeline stage holds a valid entry.

## Operation
- Stages:
  - S1 is the operand register: s1_v, s1_id, s1_a, s1_b.
  - The shared multiplier is combinational from S1.
  - S2 is the result register: rsp_valid, rsp_id, rsp_p.
- Stall rules:
  - s2_free = !rsp_valid | rsp_ready.
  - s1_free = !s1_v | s2_free.
- Arbitration (combinational):
  - When s1_free, grant the first i with req_valid[i], searching i = ptr, ptr+1, … modulo NREQ.
  - req_ready[i] = grant[i].
  - No grant when !s1_free.
- Pointer:
  - ptr resets to 0.
  - On any grant to requester g, ptr <= (g+1) mod NREQ, wrapping NREQ-1 to 0.
  - Unchanged otherwise.
- S1 load: on grant, s1_v <= 1 and capture id, a, b. If S1 advances without a new grant, s1_v <= 0.
- S2 load: when s2_free, S2 takes S1's contents (valid, id, product). If s2_free and !s1_v, rsp_valid <= 0.
- Holding: S2 holds rsp_valid, rsp_id and rsp_p stable while rsp_valid & !rsp_ready.
- Requesters may change operands only after their handshake. A dropped req_valid before grant is legal and simply loses arbitration.
- Simultaneous events:
  - A response handshake and a new grant can occur in the same cycle.
  - Full throughput is one product per cycle.
- Arithmetic:
  - Full signed 32x32 to 64-bit product; no truncation, no overflow.
  - (-2^31)*(-2^31) = 2^62.
- busy = s1_v | rsp_valid.

## Timing
- Reset values: rsp_valid 0, rsp_id 0, rsp_p 0, s1_v 0, ptr 0, busy 0.
- req_ready is 0 throughout reset.
- Reset during operation discards all in-flight products. No response is emitted for them.
- Latency:
  - Handshake at edge E0 loads S1.
  - rsp_valid is high after edge E0+1, i.e. 2 cycles from accept to visible response.
- Backpressure:
  - With S1 and S2 both full and rsp_ready low, all req_ready stay 0.
  - When rsp_ready rises, a grant is issued in that same cycle.
- A requester with req_valid held continuously is granted within NREQ grants (starvation-free).

## Configuration
- MUL_RR_SCHED_PIPE_EN defined:
  - Adds register stage SW between the Wallace tree outputs (`out1`, `out2` of `wallace_tree_32_with_boothR8`) and the 64-bit final adder.
  - SW has its own valid/id and follows the same hold/advance rule.
  - Latency is 3 cycles; throughput stays 1 per cycle.
  - busy also ORs SW valid.
- MUL_RR_SCHED_PIPE_EN undefined: `result_output` is used combinationally from S1, and latency is 2 cycles.

## Test plan
- Single request: req_valid[0], a=3, b=-5, rsp_ready=1 → req_ready[0] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_p=-15 (0xFFFFFFFFFFFFFFF1).
- All four requesters valid continuously, rsp_ready=1 → grants in order 0,1,2,3,0; one response per cycle with ids in the same order; ptr wraps 3→0.
- Corner operands: a=b=0x80000000 → rsp_p=0x4000000000000000. a=0x7FFFFFFF, b=0x80000000 → rsp_p=0xC000000080000000.
- Backpressure: hold rsp_ready=0 after two grants → rsp_p and rsp_id stable, req_ready all 0. Raise rsp_ready → the held product drains and a new grant is issued in that cycle.
- Reset mid-operation: assert rst with S1 and S2 full → rsp_valid, busy and req_ready drop immediately. After release the first grant goes to requester 0 and no stale response appears.
- With MUL_RR_SCHED_PIPE_EN defined, repeat the single-request scenario → response appears 3 cycles after accept with identical values.
